// File: rtl/multiply_pkg.sv
// Shared widths, types and arithmetic helpers for the Y-axis vertex rotator.
package multiply_pkg;

    localparam int IN_W      = 8;
    localparam int TRIG_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int OUT_W     = 9;

    // The full product of an 8-bit coordinate and a 16-bit trig value fits
    // in 24 signed bits. One extra bit holds the sum or difference of two
    // such products without overflow.
    localparam int PROD_W = IN_W + TRIG_W;
    localparam int SUM_W  = PROD_W + 1;

    localparam int OUT_MAX = 255;
    localparam int OUT_MIN = -256;

    typedef logic signed [IN_W-1:0]   coord_in_t;
    typedef logic signed [OUT_W-1:0]  coord_out_t;
    typedef logic signed [TRIG_W-1:0] trig_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    localparam sum_t SUM_SAT_HI = sum_t'(OUT_MAX);
    localparam sum_t SUM_SAT_LO = sum_t'(OUT_MIN);

    // Signed 8x16 multiply. Both operands are sign-extended to the product
    // width first, so the low PROD_W bits of the result are exact.
    function automatic prod_t mul_s(input coord_in_t a, input trig_t b);
        prod_t a_ext;
        prod_t b_ext;
        a_ext = prod_t'(a);
        b_ext = prod_t'(b);
        return a_ext * b_ext;
    endfunction

    // Clamp an already-shifted value to the signed range of the output.
    function automatic coord_out_t sat_out(input sum_t v);
        if (v > SUM_SAT_HI) begin
            return coord_out_t'(OUT_MAX);
        end else if (v < SUM_SAT_LO) begin
            return coord_out_t'(OUT_MIN);
        end else begin
            return coord_out_t'(v);
        end
    endfunction

endpackage

// File: rtl/multiply_rotate_vec.sv
// Two-stage rotation of one vertex about the Y axis.
//   stage 1: x*cos, z*sin, z*cos, x*sin and y are registered
//   stage 2: sum / difference, arithmetic shift, saturate into the output
module rotate_vec
    import multiply_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  coord_in_t v_i [2:0],
    input  trig_t     sin_i,
    input  trig_t     cos_i,
    output coord_out_t v_o [2:0]
);

    prod_t      xc_q, xc_d;
    prod_t      zs_q, zs_d;
    prod_t      zc_q, zc_d;
    prod_t      xs_q, xs_d;
    coord_out_t y_q,  y_d;

    coord_out_t out_q [2:0];
    coord_out_t out_d [2:0];

    sum_t       x_sum;
    sum_t       z_diff;
    sum_t       x_shr;
    sum_t       z_shr;

    // Stage 1 next state: the four partial products and the widened y.
    always_comb begin
        xc_d = mul_s(v_i[0], cos_i);
        zs_d = mul_s(v_i[2], sin_i);
        zc_d = mul_s(v_i[2], cos_i);
        xs_d = mul_s(v_i[0], sin_i);
        y_d  = coord_out_t'(v_i[1]);
    end

    // Stage 1 registers; a synchronous reset flushes anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            xc_q <= '0;
            zs_q <= '0;
            zc_q <= '0;
            xs_q <= '0;
            y_q  <= '0;
        end else begin
            xc_q <= xc_d;
            zs_q <= zs_d;
            zc_q <= zc_d;
            xs_q <= xs_d;
            y_q  <= y_d;
        end
    end

    // Stage 2 next state. The shift is arithmetic, so results floor toward
    // negative infinity; no rounding is applied before the clamp.
    always_comb begin
        x_sum    = sum_t'(xc_q) + sum_t'(zs_q);
        z_diff   = sum_t'(zc_q) - sum_t'(xs_q);
        x_shr    = x_sum  >>> FRAC_BITS;
        z_shr    = z_diff >>> FRAC_BITS;
        out_d[0] = sat_out(x_shr);
        out_d[1] = y_q;
        out_d[2] = sat_out(z_shr);
    end

    // Stage 2 registers drive the outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q[0] <= '0;
            out_q[1] <= '0;
            out_q[2] <= '0;
        end else begin
            out_q[0] <= out_d[0];
            out_q[1] <= out_d[1];
            out_q[2] <= out_d[2];
        end
    end

    assign v_o = out_q;

endmodule

// File: rtl/multiply.sv
// Rotates the three vertices of a triangle about the Y axis using one shared
// sin/cos pair. Accepts a triangle every clock with a fixed 2-cycle latency.
module multiply
    import multiply_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  coord_in_t  v1 [2:0],
    input  coord_in_t  v2 [2:0],
    input  coord_in_t  v3 [2:0],
    input  trig_t      sin_val,
    input  trig_t      cos_val,
    output coord_out_t v1_out [2:0],
    output coord_out_t v2_out [2:0],
    output coord_out_t v3_out [2:0]
);

    rotate_vec u_rot_v1 (
        .clk   (clk),
        .rst   (rst),
        .v_i   (v1),
        .sin_i (sin_val),
        .cos_i (cos_val),
        .v_o   (v1_out)
    );

    rotate_vec u_rot_v2 (
        .clk   (clk),
        .rst   (rst),
        .v_i   (v2),
        .sin_i (sin_val),
        .cos_i (cos_val),
        .v_o   (v2_out)
    );

    rotate_vec u_rot_v3 (
        .clk   (clk),
        .rst   (rst),
        .v_i   (v3),
        .sin_i (sin_val),
        .cos_i (cos_val),
        .v_o   (v3_out)
    );

endmodule

// File: tb/tb_multiply.sv
// Scoreboard bench for the triangle rotator: the driver pushes one record per
// clock edge, the monitor pops it after the edge and checks all nine outputs.
module tb_multiply;

    logic              clk;
    logic              rst;
    logic signed [7:0] v1 [2:0];
    logic signed [7:0] v2 [2:0];
    logic signed [7:0] v3 [2:0];
    logic signed [15:0] sin_val;
    logic signed [15:0] cos_val;
    logic signed [8:0] v1_out [2:0];
    logic signed [8:0] v2_out [2:0];
    logic signed [8:0] v3_out [2:0];

    typedef struct {
        bit rst;
        int res [9];
    } rec_t;

    rec_t q [$];
    int   total = 0;
    int   bad   = 0;

    multiply dut (
        .clk     (clk),
        .rst     (rst),
        .v1      (v1),
        .v2      (v2),
        .v3      (v3),
        .sin_val (sin_val),
        .cos_val (cos_val),
        .v1_out  (v1_out),
        .v2_out  (v2_out),
        .v3_out  (v3_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx8(input int a);
        logic signed [7:0] t;
        t = 8'(a);
        return int'(t);
    endfunction

    function automatic int sx16(input int a);
        logic signed [15:0] t;
        t = 16'(a);
        return int'(t);
    endfunction

    function automatic int clamp(input int v);
        if (v > 255)  return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    // Reference: rotation about Y with floor division by 256 and clamping.
    task automatic ref_rot(input int x, input int y, input int z,
                           input int s, input int c,
                           output int xo, output int yo, output int zo);
        xo = clamp((x * c + z * s) >>> 8);
        yo = y;
        zo = clamp((z * c - x * s) >>> 8);
    endtask

    // Apply one cycle of stimulus and record what it should produce.
    task automatic drive(input bit r, input int a [9], input int s, input int c);
        rec_t rc;
        int   xo, yo, zo;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < 3; i++) begin
            v1[i] = 8'(a[i]);
            v2[i] = 8'(a[3 + i]);
            v3[i] = 8'(a[6 + i]);
        end
        sin_val = 16'(s);
        cos_val = 16'(c);
        rc.rst = r;
        for (int vt = 0; vt < 3; vt++) begin
            ref_rot(sx8(a[3*vt]), sx8(a[3*vt + 1]), sx8(a[3*vt + 2]),
                    sx16(s), sx16(c), xo, yo, zo);
            rc.res[3*vt]     = xo;
            rc.res[3*vt + 1] = yo;
            rc.res[3*vt + 2] = zo;
        end
        q.push_back(rc);
    endtask

    // Monitor: output after edge e reflects the inputs sampled at edge e-1,
    // and is zero whenever reset was high at edge e or edge e-1.
    initial begin : monitor
        rec_t cur;
        rec_t last;
        bit   have_last;
        bit   seen;
        int   act [9];
        int   exp_v;
        have_last = 1'b0;
        seen      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                if (seen) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty at %0t: got size 0 want >0", $time);
                end
            end else begin
                seen = 1'b1;
                cur  = q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    act[i]     = int'(v1_out[i]);
                    act[3 + i] = int'(v2_out[i]);
                    act[6 + i] = int'(v3_out[i]);
                end
                for (int k = 0; k < 9; k++) begin
                    if (cur.rst || !have_last || last.rst) exp_v = 0;
                    else                                   exp_v = last.res[k];
                    total++;
                    if (act[k] !== exp_v) begin
                        bad++;
                        $display("FAIL v%0d_out[%0d] at %0t: got %0d want %0d",
                                 k / 3 + 1, k % 3, $time, act[k], exp_v);
                    end
                end
                last      = cur;
                have_last = 1'b1;
            end
        end
    end

    initial begin : stimulus
        int a [9];
        int s, c;
        int sel;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v1[i] = '0;
            v2[i] = '0;
            v3[i] = '0;
        end
        sin_val = '0;
        cos_val = '0;

        // Reset held two cycles with nonzero inputs, then one zero-output cycle.
        a = '{-2, 8, 3, -2, 2, -3, 9, 0, -7};
        drive(1'b1, a, 'h00C0, 'h00A0);
        drive(1'b1, a, 'h00C0, 'h00A0);

        // Basic rotation with sin=0.75, cos=0.625.
        drive(1'b0, a, 'h00C0, 'h00A0);

        // Identity and quarter-turn.
        a = '{-128, 127, 5, 10, 3, 20, 0, -1, 1};
        drive(1'b0, a, 'h0000, 'h0100);
        drive(1'b0, a, 'h0100, 'h0000);

        // Saturation at both ends.
        a = '{127, 0, 127, -128, 0, -128, 127, -128, -128};
        drive(1'b0, a, 'h0200, 'h0200);
        a = '{-128, 0, -128, 127, 0, 127, -128, 127, 127};
        drive(1'b0, a, 'h0200, 'h0200);

        // Back-to-back changing inputs.
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 9; k++) a[k] = int'($urandom_range(0, 255)) - 128;
            drive(1'b0, a, int'($urandom_range(0, 512)) - 256,
                  int'($urandom_range(0, 512)) - 256);
        end

        // Single-cycle reset while data is in flight, then fresh data.
        drive(1'b1, a, 'h00C0, 'h00A0);
        a = '{-2, 8, 3, -2, 2, -3, 9, 0, -7};
        drive(1'b0, a, 'h00C0, 'h00A0);
        drive(1'b0, a, 'h00A0, 'h00C0);

        // Random traffic with occasional resets and out-of-range trig values.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 9; k++) a[k] = int'($urandom_range(0, 255)) - 128;
            sel = int'($urandom_range(0, 3));
            if (sel == 0) begin
                s = int'($urandom_range(0, 65535)) - 32768;
                c = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                s = int'($urandom_range(0, 1024)) - 512;
                c = int'($urandom_range(0, 1024)) - 512;
            end
            drive($urandom_range(0, 19) == 0, a, s, c);
        end

        // Drain the pipeline.
        a = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(1'b0, a, 0, 0);
        drive(1'b0, a, 0, 0);
        drive(1'b0, a, 0, 0);
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
